// File: rtl/pipe_stage_skid_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_reg_if
// Handshake/bus bundle for one pipeline stage register.
//   i_valid / o_ready / i_ctrl / i_data : upstream side (producer -> stage)
//   o_valid / i_ready / o_ctrl / o_data : downstream side (stage -> consumer)
// Modports:
//   slave  : the stage register's view (takes i_*, drives o_*)
//   master : the surrounding pipeline's view (drives i_*, takes o_*)
// -----------------------------------------------------------------------------
interface pipe_stage_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              i_valid;
  logic              o_ready;
  logic [CTRL_W-1:0] i_ctrl;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              i_ready;
  logic [CTRL_W-1:0] o_ctrl;
  logic [DATA_W-1:0] o_data;

  modport slave (
    input  i_valid, i_ctrl, i_data, i_ready,
    output o_ready, o_valid, o_ctrl, o_data
  );

  modport master (
    output i_valid, i_ctrl, i_data, i_ready,
    input  o_ready, o_valid, o_ctrl, o_data
  );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_reg
// Generic inter-stage pipeline register with a 2-entry skid buffer. Carries a
// control bundle and a data bundle under valid/ready, keeps o_ready registered
// while sustaining one beat per cycle, and turns flushed beats into bubbles by
// forcing the control bundle to CTRL_NOP.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   i_flush      in   squash all held beats at this clock edge
//   o_stall_cnt  out  32-bit backpressure cycle count (0 unless enabled)
//   bus          slave modport of pipe_stage_skid_reg_if
//                (i_valid/o_ready/i_ctrl/i_data upstream,
//                 o_valid/i_ready/o_ctrl/o_data downstream)
//
// Optional feature macro: PIPE_STALL_CNT_EN
//   defined   : o_stall_cnt counts cycles with o_valid=1 & i_ready=0,
//               saturating, cleared only by reset.
//   undefined : o_stall_cnt is tied to zero.
// -----------------------------------------------------------------------------
module pipe_stage_skid_reg #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  output logic [31:0]           o_stall_cnt,
  pipe_stage_skid_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_r;
  logic              o_valid_r;
  logic              o_ready_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;

  logic              in_fire_s;
  logic              out_fire_s;

  assign in_fire_s  = bus.i_valid & o_ready_r;
  assign out_fire_s = o_valid_r & bus.i_ready;

  // Outputs come straight from flops; main_ctrl_r already holds CTRL_NOP
  // whenever the stage has no valid beat.
  assign bus.o_valid = o_valid_r;
  assign bus.o_ready = o_ready_r;
  assign bus.o_ctrl  = main_ctrl_r;
  assign bus.o_data  = main_data_r;

  // Skid-buffer FSM: state, handshake flags and main/skid storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_EMPTY;
      o_valid_r   <= 1'b0;
      o_ready_r   <= 1'b1;
      main_ctrl_r <= CTRL_NOP;
      main_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
    end else if (i_flush) begin
      // Flush wins over a simultaneous in_fire; o_data keeps its old value.
      state_r     <= ST_EMPTY;
      o_valid_r   <= 1'b0;
      o_ready_r   <= 1'b1;
      main_ctrl_r <= CTRL_NOP;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_ctrl_r <= bus.i_ctrl;
            main_data_r <= bus.i_data;
            o_valid_r   <= 1'b1;
            state_r     <= ST_ONE;
          end else begin
            state_r     <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_ctrl_r <= bus.i_ctrl;
            main_data_r <= bus.i_data;
          end else if (in_fire_s) begin
            // Downstream stalled: park the new beat, drop ready next cycle.
            skid_ctrl_r <= bus.i_ctrl;
            skid_data_r <= bus.i_data;
            o_ready_r   <= 1'b0;
            state_r     <= ST_FULL;
          end else if (out_fire_s) begin
            o_valid_r   <= 1'b0;
            main_ctrl_r <= CTRL_NOP;
            state_r     <= ST_EMPTY;
          end else begin
            state_r     <= ST_ONE;
          end
        end
        ST_FULL: begin
          // o_ready_r is 0 here, so no beat can arrive in this state.
          if (out_fire_s) begin
            main_ctrl_r <= skid_ctrl_r;
            main_data_r <= skid_data_r;
            o_ready_r   <= 1'b1;
            state_r     <= ST_ONE;
          end else begin
            state_r     <= ST_FULL;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          o_valid_r   <= 1'b0;
          o_ready_r   <= 1'b1;
          main_ctrl_r <= CTRL_NOP;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating backpressure counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
    end else if (o_valid_r && !bus.i_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_stall_cnt = stall_cnt_r;
`else
  assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;
  localparam int         DATA_W = 32;
  localparam int         CTRL_W = 8;
  localparam logic [7:0] NOP    = 8'h5A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_flush = 1'b0;
  logic [31:0] o_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (i_flush),
    .o_stall_cnt (o_stall_cnt),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ctrl_of(input int k);
    return 8'h10 + k[7:0];
  endfunction

  function automatic logic [31:0] data_of(input int k);
    return 32'hD000_0000 + k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int k);
    bus.i_valid = v;
    bus.i_ctrl  = ctrl_of(k);
    bus.i_data  = data_of(k);
  endtask

  task automatic test_reset();
    bus.i_ready = 1'b1;
    drive(1'b1, 1);
    #2 reset = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", bus.o_valid); end
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", bus.o_ready); end
    n_checks++; if (bus.o_ctrl !== NOP) begin n_fail++; $display("FAIL rst_ctrl got %h exp %h", bus.o_ctrl, NOP); end
    n_checks++; if (bus.o_data !== 32'd0) begin n_fail++; $display("FAIL rst_data got %h exp 0", bus.o_data); end
    n_checks++; if (o_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_stall got %0d exp 0", o_stall_cnt); end
    reset = 1'b1;
    tick();
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL rel_valid got %b exp 1", bus.o_valid); end
    n_checks++; if (bus.o_data !== data_of(1)) begin n_fail++; $display("FAIL rel_data got %h exp %h", bus.o_data, data_of(1)); end
    n_checks++; if (bus.o_ctrl !== ctrl_of(1)) begin n_fail++; $display("FAIL rel_ctrl got %h exp %h", bus.o_ctrl, ctrl_of(1)); end
    drive(1'b0, 0);
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rel_drain_valid got %b exp 0", bus.o_valid); end
    n_checks++; if (bus.o_ctrl !== NOP) begin n_fail++; $display("FAIL rel_drain_ctrl got %h exp %h", bus.o_ctrl, NOP); end
  endtask

  task automatic test_streaming();
    bus.i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, k);
      tick();
      n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b exp 1", k, bus.o_valid); end
      n_checks++; if (bus.o_data !== data_of(k)) begin n_fail++; $display("FAIL stream_data[%0d] got %h exp %h", k, bus.o_data, data_of(k)); end
      n_checks++; if (bus.o_ctrl !== ctrl_of(k)) begin n_fail++; $display("FAIL stream_ctrl[%0d] got %h exp %h", k, bus.o_ctrl, ctrl_of(k)); end
      n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b exp 1", k, bus.o_ready); end
    end
    drive(1'b0, 0);
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid got %b exp 0", bus.o_valid); end
  endtask

  task automatic test_backpressure();
    bus.i_ready = 1'b0;
    drive(1'b1, 21);  // A
    tick();
    n_checks++; if (bus.o_data !== data_of(21)) begin n_fail++; $display("FAIL bp_a_data got %h exp %h", bus.o_data, data_of(21)); end
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_one_ready got %b exp 1", bus.o_ready); end
    drive(1'b1, 22);  // B -> skid
    tick();
    n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b exp 0", bus.o_ready); end
    n_checks++; if (bus.o_data !== data_of(21)) begin n_fail++; $display("FAIL bp_hold_data got %h exp %h", bus.o_data, data_of(21)); end
    drive(1'b1, 23);  // C, must not be accepted while full
    tick();
    n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_c_ready got %b exp 0", bus.o_ready); end
    n_checks++; if (bus.o_data !== data_of(21) || bus.o_ctrl !== ctrl_of(21)) begin n_fail++; $display("FAIL bp_stable got %h/%h exp %h/%h", bus.o_ctrl, bus.o_data, ctrl_of(21), data_of(21)); end
    bus.i_ready = 1'b1;
    tick();
    n_checks++; if (bus.o_data !== data_of(22) || bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_b_out got %h v=%b exp %h", bus.o_data, bus.o_valid, data_of(22)); end
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %b exp 1", bus.o_ready); end
    tick();
    n_checks++; if (bus.o_data !== data_of(23) || bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_c_out got %h v=%b exp %h", bus.o_data, bus.o_valid, data_of(23)); end
    drive(1'b0, 0);
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid got %b exp 0", bus.o_valid); end
  endtask

  task automatic test_async_reset();
    bus.i_ready = 1'b0;
    drive(1'b1, 41);
    tick();
    drive(1'b1, 42);
    tick();
    n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL ar_full_ready got %b exp 0", bus.o_ready); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b exp 0", bus.o_valid); end
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready got %b exp 1", bus.o_ready); end
    n_checks++; if (bus.o_ctrl !== NOP) begin n_fail++; $display("FAIL ar_ctrl got %h exp %h", bus.o_ctrl, NOP); end
    n_checks++; if (bus.o_data !== 32'd0) begin n_fail++; $display("FAIL ar_data got %h exp 0", bus.o_data); end
    n_checks++; if (o_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL ar_stall got %0d exp 0", o_stall_cnt); end
    tick();
    drive(1'b0, 0);
    bus.i_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL ar_stale[%0d] got %b exp 0", i, bus.o_valid); end
    end
  endtask

  task automatic test_stall_cnt();
    logic [31:0] exp_cnt;
`ifdef PIPE_STALL_CNT_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    bus.i_ready = 1'b0;
    drive(1'b1, 51);
    tick();
    drive(1'b0, 0);
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (o_stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL stall_cnt got %0d exp %0d", o_stall_cnt, exp_cnt); end
    bus.i_ready = 1'b1;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL stall_flush_valid got %b exp 0", bus.o_valid); end
    tick();
    n_checks++; if (o_stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL stall_after_flush got %0d exp %0d", o_stall_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    bus.i_ready = 1'b0;
    drive(1'b1, 61);
    tick();
    drive(1'b1, 62);
    tick();
    n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL fl_full_ready got %b exp 0", bus.o_ready); end
    drive(1'b1, 63);  // D, dropped by flush
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    drive(1'b0, 0);
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got %b exp 0", bus.o_valid); end
    n_checks++; if (bus.o_ctrl !== NOP) begin n_fail++; $display("FAIL fl_ctrl got %h exp %h", bus.o_ctrl, NOP); end
    n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready got %b exp 1", bus.o_ready); end
    n_checks++; if (bus.o_data !== data_of(61)) begin n_fail++; $display("FAIL fl_data_kept got %h exp %h", bus.o_data, data_of(61)); end
    bus.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL fl_no_d[%0d] got %b data %h exp 0", i, bus.o_valid, bus.o_data); end
    end
    drive(1'b1, 64);
    tick();
    drive(1'b0, 0);
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== data_of(64)) begin n_fail++; $display("FAIL fl_resume got %h v=%b exp %h", bus.o_data, bus.o_valid, data_of(64)); end
    tick();
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ctrl  = 8'd0;
    bus.i_data  = 32'd0;
    bus.i_ready = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_async_reset();
    test_stall_cnt();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
